dispatch_queue: RTL and testbench
=================================

Name: dispatch_queue

Overview:
Buffered, parametrised dispatch stage between the decoder and the rename/issue resources (regfile, reorder buffer, reservation station).
- Accepts decoded instructions into a DEPTH-entry FIFO.
- Dispatches the head entry when ROB and RS both have room.
- Resolves source operands from the regfile, the ROB or a same-cycle CDB broadcast.
- Supports flush on branch mispredict.
- Decouples decoder throughput from back-end stalls.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ID_W, 32, data/immediate width
ROB_W, 4, ROB tag width; tag 0 means "no dependency"
REG_W, 5, architectural register index width
OP_W, 6, opcode width (encoding from constant.vh)
ADDR_W, 32, PC/target width

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous, active-high reset
rdy_in  in  1  global enable; low freezes all state
clr_in  in  1  flush (mispredict); empties queue
dec_en_in  in  1  decoder presents an instruction
dec_rs_in/dec_rt_in/dec_rd_in  in  REG_W  source and destination registers
dec_imm_in  in  ID_W  immediate
dec_opcode_in  in  OP_W  opcode
dec_pc_in/dec_target_in  in  ADDR_W  PC and predicted target
dec_taken_in  in  1  branch-predictor taken bit
dq_full_out  out  1  queue full; decoder must hold
rf_rs_out/rf_rt_out  out  REG_W  regfile read indices (head rs/rt)
rf_rs_busy_in/rf_rt_busy_in  in  1  register awaiting a ROB result
rf_rs_val_in/rf_rt_val_in  in  ID_W  register values
rf_rs_tag_in/rf_rt_tag_in  in  ROB_W  producing ROB tags
rf_rd_en_out  out  1  rename rd this cycle
rf_rd_out  out  REG_W  rd index
rf_tag_out  out  ROB_W  new tag for rd
rob_rs_h_out/rob_rt_h_out  out  ROB_W  ROB lookup tags
rob_rs_ready_in/rob_rt_ready_in  in  1  ROB entry has its result
rob_rs_val_in/rob_rt_val_in  in  ID_W  ROB results
rob_b_in  in  ROB_W  next free ROB tag
rob_full_in  in  1  ROB cannot accept
rs_full_in  in  1  reservation station cannot accept
cdb_en_in  in  1  CDB broadcast valid
cdb_tag_in  in  ROB_W  CDB tag
cdb_val_in  in  ID_W  CDB value
disp_en_out  out  1  dispatch fire (to ROB and RS)
disp_opcode_out  out  OP_W  opcode
disp_rd_out  out  REG_W  destination register (ROB)
disp_pc_out/disp_target_out  out  ADDR_W  PC and predicted target
disp_taken_out  out  1  predicted taken
disp_a_out  out  ID_W  immediate
disp_qj_out/disp_qk_out  out  ROB_W  operand tags (0 = value valid)
disp_vj_out/disp_vk_out  out  ID_W  operand values
disp_dest_out  out  ROB_W  equals rob_b_in

Behaviour:
- Reset (async, any time, including mid-flush or mid-dispatch): head = tail = 0, count = 0.
  - dq_full_out = 0; disp_en_out = rf_rd_en_out = 0.
  - Every head-derived output is 0 while the queue is empty.
- Enqueue: at the rising edge where rdy_in && !clr_in && dec_en_in && !dq_full_out, write the entry at tail and advance tail modulo DEPTH.
  - dq_full_out = (count == DEPTH), combinational from registered count.
  - An enqueue attempted while full is dropped; the decoder must hold.
- Fire = rdy_in && !clr_in && count != 0 && !rob_full_in && !rs_full_in.
  - disp_en_out = fire, combinational.
  - Head advances at the edge ending the fire cycle.
- Latency: an instruction enqueued at edge N can fire no earlier than cycle N+1. There is no combinational bypass from the decoder to the outputs.
- Throughput: one dispatch per cycle.
- Simultaneous enqueue and dispatch: count is unchanged, both pointers advance. This is legal at any non-full count.
- Pointer wrap: ptr width = clog2(DEPTH); count width = clog2(DEPTH+1).
- Operand j (k identical, using rt):
  - Not busy: vj = rf value, qj = 0, rob_rs_h_out = 0.
  - Busy: rob_rs_h_out = rf tag, then in priority order:
    - ROB ready: vj = ROB value, qj = 0.
    - Else cdb_en_in && cdb_tag_in == rf tag: vj = cdb_val_in, qj = 0.
    - Else vj = 0, qj = rf tag.
- rf_rd_en_out = fire && opcode not in [BEQ..BGEU] && not in [SB..SW] && rd != 0. It renames rd to rob_b_in at that edge, so the next head sees the updated busy/tag.
- Flush (clr_in high at an edge): count, head and tail return to 0. disp_en_out and rf_rd_en_out are 0 throughout the flush cycle; any simultaneous enqueue is discarded.
- rdy_in low: no state changes; disp_en_out = rf_rd_en_out = 0.

Test Plan:
- Reset mid-stream with 3 entries queued -> count 0, dq_full_out 0, disp_en_out 0 immediately (asynchronous).
- Enqueue 4 instructions with rob_full_in = 1 (DEPTH = 4) -> dq_full_out = 1 after the 4th edge; a 5th dec_en_in is dropped. Release rob_full_in -> 4 dispatches in 4 consecutive cycles, in order.
- Head ADD x3,x1,x2: x1 busy with tag 5 and ROB not ready, CDB broadcasts tag 5 value 0x1234 that cycle -> vj = 0x1234, qj = 0. x2 busy with tag 6, not ready, no CDB hit -> qk = 6, vk = 0.
- Back-to-back ADDI x5 then ADD x6,x5,x5 with rob_b_in = 2 -> ADDI fires with rf_rd_en_out = 1, rf_tag_out = 2. Next cycle the ADD reads busy tag 2 -> qj = qk = 2.
- SW or BEQ at head with rd field 7 -> disp_en_out = 1, rf_rd_en_out = 0.
- clr_in asserted with 2 entries queued and dec_en_in = 1 -> next cycle count = 0, no dispatch, new instruction not captured.

Source files
------------

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - decoded-instruction FIFO that resolves operands and dispatches the head to ROB/RS
module dispatch_queue #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 32,
    parameter int ROB_W   = 4,
    parameter int REG_W   = 5,
    parameter int OP_W    = 6,
    parameter int ADDR_W  = 32,
    parameter int OP_BEQ  = 5,
    parameter int OP_BGEU = 10,
    parameter int OP_SB   = 16,
    parameter int OP_SW   = 18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic              dec_en_in,
    input  logic [REG_W-1:0]  dec_rs_in,
    input  logic [REG_W-1:0]  dec_rt_in,
    input  logic [REG_W-1:0]  dec_rd_in,
    input  logic [ID_W-1:0]   dec_imm_in,
    input  logic [OP_W-1:0]   dec_opcode_in,
    input  logic [ADDR_W-1:0] dec_pc_in,
    input  logic [ADDR_W-1:0] dec_target_in,
    input  logic              dec_taken_in,
    output logic              dq_full_out,
    output logic [REG_W-1:0]  rf_rs_out,
    output logic [REG_W-1:0]  rf_rt_out,
    input  logic              rf_rs_busy_in,
    input  logic              rf_rt_busy_in,
    input  logic [ID_W-1:0]   rf_rs_val_in,
    input  logic [ID_W-1:0]   rf_rt_val_in,
    input  logic [ROB_W-1:0]  rf_rs_tag_in,
    input  logic [ROB_W-1:0]  rf_rt_tag_in,
    output logic              rf_rd_en_out,
    output logic [REG_W-1:0]  rf_rd_out,
    output logic [ROB_W-1:0]  rf_tag_out,
    output logic [ROB_W-1:0]  rob_rs_h_out,
    output logic [ROB_W-1:0]  rob_rt_h_out,
    input  logic              rob_rs_ready_in,
    input  logic              rob_rt_ready_in,
    input  logic [ID_W-1:0]   rob_rs_val_in,
    input  logic [ID_W-1:0]   rob_rt_val_in,
    input  logic [ROB_W-1:0]  rob_b_in,
    input  logic              rob_full_in,
    input  logic              rs_full_in,
    input  logic              cdb_en_in,
    input  logic [ROB_W-1:0]  cdb_tag_in,
    input  logic [ID_W-1:0]   cdb_val_in,
    output logic              disp_en_out,
    output logic [OP_W-1:0]   disp_opcode_out,
    output logic [REG_W-1:0]  disp_rd_out,
    output logic [ADDR_W-1:0] disp_pc_out,
    output logic [ADDR_W-1:0] disp_target_out,
    output logic              disp_taken_out,
    output logic [ID_W-1:0]   disp_a_out,
    output logic [ROB_W-1:0]  disp_qj_out,
    output logic [ROB_W-1:0]  disp_qk_out,
    output logic [ID_W-1:0]   disp_vj_out,
    output logic [ID_W-1:0]   disp_vk_out,
    output logic [ROB_W-1:0]  disp_dest_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [OP_W-1:0] BEQ_C  = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] BGEU_C = OP_W'(OP_BGEU);
    localparam logic [OP_W-1:0] SB_C   = OP_W'(OP_SB);
    localparam logic [OP_W-1:0] SW_C   = OP_W'(OP_SW);

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [ID_W-1:0]   imm;
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
        logic              taken;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           head_ent;
    entry_t           new_ent;
    logic             not_empty, full, enq, fire, writes_rd;

    assign head_ent  = not_empty ? mem_q[head_q] : '0;
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign enq       = rdy_in && !clr_in && dec_en_in && !full;
    assign fire      = rdy_in && !clr_in && not_empty && !rob_full_in && !rs_full_in;
    assign new_ent   = '{rs: dec_rs_in, rt: dec_rt_in, rd: dec_rd_in, imm: dec_imm_in,
                         opcode: dec_opcode_in, pc: dec_pc_in, target: dec_target_in,
                         taken: dec_taken_in};

    // Branches and stores carry an rd field but never produce a register result.
    assign writes_rd = !((head_ent.opcode >= BEQ_C) && (head_ent.opcode <= BGEU_C)) &&
                       !((head_ent.opcode >= SB_C) && (head_ent.opcode <= SW_C)) &&
                       (head_ent.rd != '0);

    assign dq_full_out     = full;
    assign disp_en_out     = fire;
    assign rf_rd_en_out    = fire && writes_rd;
    assign rf_rd_out       = head_ent.rd;
    assign rf_tag_out      = rob_b_in;
    assign rf_rs_out       = head_ent.rs;
    assign rf_rt_out       = head_ent.rt;
    assign disp_opcode_out = head_ent.opcode;
    assign disp_rd_out     = head_ent.rd;
    assign disp_pc_out     = head_ent.pc;
    assign disp_target_out = head_ent.target;
    assign disp_taken_out  = head_ent.taken;
    assign disp_a_out      = head_ent.imm;
    assign disp_dest_out   = rob_b_in;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in && clr_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                mem_d[tail_q] = new_ent;
                tail_d        = tail_q + PTR_W'(1);
            end
            if (fire) begin
                head_d = head_q + PTR_W'(1);
            end
            if (enq && !fire) begin
                count_d = count_q + CNT_W'(1);
            end else if (fire && !enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // Operand priority: regfile value, then ROB result, then same-cycle CDB hit, else wait on tag.
    always_comb begin
        rob_rs_h_out = '0;
        rob_rt_h_out = '0;
        disp_vj_out  = '0;
        disp_vk_out  = '0;
        disp_qj_out  = '0;
        disp_qk_out  = '0;
        if (not_empty) begin
            if (!rf_rs_busy_in) begin
                disp_vj_out = rf_rs_val_in;
            end else begin
                rob_rs_h_out = rf_rs_tag_in;
                if (rob_rs_ready_in) begin
                    disp_vj_out = rob_rs_val_in;
                end else if (cdb_en_in && (cdb_tag_in == rf_rs_tag_in)) begin
                    disp_vj_out = cdb_val_in;
                end else begin
                    disp_qj_out = rf_rs_tag_in;
                end
            end
            if (!rf_rt_busy_in) begin
                disp_vk_out = rf_rt_val_in;
            end else begin
                rob_rt_h_out = rf_rt_tag_in;
                if (rob_rt_ready_in) begin
                    disp_vk_out = rob_rt_val_in;
                end else if (cdb_en_in && (cdb_tag_in == rf_rt_tag_in)) begin
                    disp_vk_out = cdb_val_in;
                end else begin
                    disp_qk_out = rf_rt_tag_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - self-checking bench for dispatch_queue with a queue-based reference model
module tb_dispatch_queue;
    localparam int DEPTH   = 4;
    localparam int OP_BEQ  = 5;
    localparam int OP_BGEU = 10;
    localparam int OP_SB   = 16;
    localparam int OP_SW   = 18;
    localparam logic [5:0] ADDI = 6'd19;
    localparam logic [5:0] ADD  = 6'd28;
    localparam logic [5:0] BEQ  = 6'd5;
    localparam logic [5:0] SW   = 6'd18;

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, clr_in = 1'b0;
    logic        dec_en_in = 1'b0;
    logic [4:0]  dec_rs_in = '0, dec_rt_in = '0, dec_rd_in = '0;
    logic [31:0] dec_imm_in = '0, dec_pc_in = '0, dec_target_in = '0;
    logic [5:0]  dec_opcode_in = '0;
    logic        dec_taken_in = 1'b0;
    logic        dq_full_out;
    logic [4:0]  rf_rs_out, rf_rt_out, rf_rd_out;
    logic        rf_rs_busy_in, rf_rt_busy_in;
    logic [31:0] rf_rs_val_in, rf_rt_val_in;
    logic [3:0]  rf_rs_tag_in, rf_rt_tag_in;
    logic        rf_rd_en_out;
    logic [3:0]  rf_tag_out, rob_rs_h_out, rob_rt_h_out;
    logic        rob_rs_ready_in = 1'b0, rob_rt_ready_in = 1'b0;
    logic [31:0] rob_rs_val_in = '0, rob_rt_val_in = '0;
    logic [3:0]  rob_b_in = 4'd1;
    logic        rob_full_in = 1'b0, rs_full_in = 1'b0;
    logic        cdb_en_in = 1'b0;
    logic [3:0]  cdb_tag_in = '0;
    logic [31:0] cdb_val_in = '0;
    logic        disp_en_out, disp_taken_out;
    logic [5:0]  disp_opcode_out;
    logic [4:0]  disp_rd_out;
    logic [31:0] disp_pc_out, disp_target_out, disp_a_out, disp_vj_out, disp_vk_out;
    logic [3:0]  disp_qj_out, disp_qk_out, disp_dest_out;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
    } ent_t;

    ent_t        mq[$];
    logic        rf_busy [32];
    logic [3:0]  rf_tag  [32];
    logic [31:0] rf_val  [32];
    int          checks = 0;
    int          errors = 0;

    assign rf_rs_busy_in = rf_busy[rf_rs_out];
    assign rf_rt_busy_in = rf_busy[rf_rt_out];
    assign rf_rs_tag_in  = rf_tag[rf_rs_out];
    assign rf_rt_tag_in  = rf_tag[rf_rt_out];
    assign rf_rs_val_in  = rf_val[rf_rs_out];
    assign rf_rt_val_in  = rf_val[rf_rt_out];

    dispatch_queue #(.DEPTH(DEPTH), .OP_BEQ(OP_BEQ), .OP_BGEU(OP_BGEU), .OP_SB(OP_SB), .OP_SW(OP_SW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .dec_en_in(dec_en_in), .dec_rs_in(dec_rs_in), .dec_rt_in(dec_rt_in), .dec_rd_in(dec_rd_in),
        .dec_imm_in(dec_imm_in), .dec_opcode_in(dec_opcode_in), .dec_pc_in(dec_pc_in),
        .dec_target_in(dec_target_in), .dec_taken_in(dec_taken_in), .dq_full_out(dq_full_out),
        .rf_rs_out(rf_rs_out), .rf_rt_out(rf_rt_out), .rf_rs_busy_in(rf_rs_busy_in),
        .rf_rt_busy_in(rf_rt_busy_in), .rf_rs_val_in(rf_rs_val_in), .rf_rt_val_in(rf_rt_val_in),
        .rf_rs_tag_in(rf_rs_tag_in), .rf_rt_tag_in(rf_rt_tag_in), .rf_rd_en_out(rf_rd_en_out),
        .rf_rd_out(rf_rd_out), .rf_tag_out(rf_tag_out), .rob_rs_h_out(rob_rs_h_out),
        .rob_rt_h_out(rob_rt_h_out), .rob_rs_ready_in(rob_rs_ready_in), .rob_rt_ready_in(rob_rt_ready_in),
        .rob_rs_val_in(rob_rs_val_in), .rob_rt_val_in(rob_rt_val_in), .rob_b_in(rob_b_in),
        .rob_full_in(rob_full_in), .rs_full_in(rs_full_in), .cdb_en_in(cdb_en_in),
        .cdb_tag_in(cdb_tag_in), .cdb_val_in(cdb_val_in), .disp_en_out(disp_en_out),
        .disp_opcode_out(disp_opcode_out), .disp_rd_out(disp_rd_out), .disp_pc_out(disp_pc_out),
        .disp_target_out(disp_target_out), .disp_taken_out(disp_taken_out), .disp_a_out(disp_a_out),
        .disp_qj_out(disp_qj_out), .disp_qk_out(disp_qk_out), .disp_vj_out(disp_vj_out),
        .disp_vk_out(disp_vk_out), .disp_dest_out(disp_dest_out)
    );

    initial forever #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    function automatic logic no_result(input logic [5:0] op);
        return (op >= 6'(OP_BEQ) && op <= 6'(OP_BGEU)) || (op >= 6'(OP_SB) && op <= 6'(OP_SW));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        ent_t        h;
        logic        ne, ef, eren;
        logic [4:0]  src [2];
        logic        rr [2];
        logic [31:0] rv [2];
        logic [31:0] ev [2];
        logic [3:0]  eq [2];
        logic [3:0]  eh [2];
        h  = '0;
        ne = mq.size() != 0;
        if (ne) h = mq[0];
        ef   = rdy_in && !clr_in && ne && !rob_full_in && !rs_full_in;
        eren = ef && !no_result(h.op) && h.rd != 0;
        src[0] = h.rs;            src[1] = h.rt;
        rr[0]  = rob_rs_ready_in; rr[1]  = rob_rt_ready_in;
        rv[0]  = rob_rs_val_in;   rv[1]  = rob_rt_val_in;
        for (int i = 0; i < 2; i++) begin
            ev[i] = '0; eq[i] = '0; eh[i] = '0;
            if (ne) begin
                if (!rf_busy[src[i]]) ev[i] = rf_val[src[i]];
                else begin
                    eh[i] = rf_tag[src[i]];
                    if (rr[i]) ev[i] = rv[i];
                    else if (cdb_en_in && cdb_tag_in == rf_tag[src[i]]) ev[i] = cdb_val_in;
                    else eq[i] = rf_tag[src[i]];
                end
            end
        end
        chk("dq_full", dq_full_out, mq.size() == DEPTH);
        chk("disp_en", disp_en_out, ef);
        chk("rf_rd_en", rf_rd_en_out, eren);
        chk("rf_rd", rf_rd_out, h.rd);
        chk("rf_tag", rf_tag_out, rob_b_in);
        chk("rf_rs", rf_rs_out, h.rs);
        chk("rf_rt", rf_rt_out, h.rt);
        chk("opcode", disp_opcode_out, h.op);
        chk("disp_rd", disp_rd_out, h.rd);
        chk("pc", disp_pc_out, h.pc);
        chk("target", disp_target_out, h.tgt);
        chk("taken", disp_taken_out, h.taken);
        chk("imm", disp_a_out, h.imm);
        chk("dest", disp_dest_out, rob_b_in);
        chk("rob_rs_h", rob_rs_h_out, eh[0]);
        chk("rob_rt_h", rob_rt_h_out, eh[1]);
        chk("vj", disp_vj_out, ev[0]);
        chk("vk", disp_vk_out, ev[1]);
        chk("qj", disp_qj_out, eq[0]);
        chk("qk", disp_qk_out, eq[1]);
    endtask

    // Compare on the falling edge, then advance the model at the rising edge from the pre-edge inputs.
    task automatic step();
        logic ef, een;
        ent_t h;
        @(negedge clk_in);
        compare_all();
        @(posedge clk_in);
        if (!rst_in && rdy_in) begin
            if (clr_in) mq.delete();
            else begin
                ef  = mq.size() != 0 && !rob_full_in && !rs_full_in;
                een = dec_en_in && mq.size() < DEPTH;
                if (ef) begin
                    h = mq.pop_front();
                    if (!no_result(h.op) && h.rd != 0) begin
                        rf_busy[h.rd] = 1'b1;
                        rf_tag[h.rd]  = rob_b_in;
                    end
                end
                if (een) mq.push_back('{rs: dec_rs_in, rt: dec_rt_in, rd: dec_rd_in, imm: dec_imm_in,
                                        op: dec_opcode_in, pc: dec_pc_in, tgt: dec_target_in,
                                        taken: dec_taken_in});
            end
        end
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] pc);
        dec_opcode_in = op; dec_rs_in = rs; dec_rt_in = rt; dec_rd_in = rd;
        dec_pc_in = pc; dec_imm_in = pc ^ 32'h0000_A5A5; dec_target_in = pc + 32'h40;
        dec_taken_in = pc[2];
        dec_en_in = 1'b1;
    endtask

    task automatic enq(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] pc);
        drive(op, rs, rt, rd, pc);
        step();
        dec_en_in = 1'b0;
    endtask

    task automatic clear_rf();
        for (int i = 0; i < 32; i++) begin
            rf_busy[i] = 1'b0;
            rf_tag[i]  = '0;
            rf_val[i]  = (i == 0) ? 32'h0 : 32'h1000 + i;
        end
    endtask

    initial begin
        clear_rf();
        #12;
        chk("hand_reset_full", dq_full_out, 1'b0);
        chk("hand_reset_en", disp_en_out, 1'b0);
        chk("hand_reset_rden", rf_rd_en_out, 1'b0);
        chk("hand_reset_pc", disp_pc_out, 32'h0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Fill with ROB full, drop a fifth, then drain in order.
        rob_full_in = 1'b1;
        for (int i = 0; i < 4; i++) enq(ADDI, 5'd0, 5'd0, 5'(10 + i), 32'h100 + 32'(4 * i));
        #1 chk("hand_full_after4", dq_full_out, 1'b1);
        enq(ADDI, 5'd0, 5'd0, 5'd20, 32'h200);
        chk("hand_full_after5", dq_full_out, 1'b1);
        rob_full_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("hand_drain_en", disp_en_out, 1'b1);
            chk("hand_drain_pc", disp_pc_out, 32'h100 + 32'(4 * i));
            step();
        end
        #1 chk("hand_drained_en", disp_en_out, 1'b0);

        // Asynchronous reset with three entries queued.
        rob_full_in = 1'b1;
        for (int i = 0; i < 3; i++) enq(ADD, 5'd1, 5'd2, 5'd3, 32'h180 + 32'(4 * i));
        rob_full_in = 1'b0;
        #1 chk("hand_prereset_en", disp_en_out, 1'b1);
        rst_in = 1'b1;
        mq.delete();
        #1 chk("hand_async_en", disp_en_out, 1'b0);
        chk("hand_async_full", dq_full_out, 1'b0);
        chk("hand_async_rs", rf_rs_out, 5'd0);
        rst_in = 1'b0;
        step();

        // Operand resolution: CDB hit on rs, pending tag on rt.
        clear_rf();
        rf_busy[1] = 1'b1; rf_tag[1] = 4'd5;
        rf_busy[2] = 1'b1; rf_tag[2] = 4'd6;
        enq(ADD, 5'd1, 5'd2, 5'd3, 32'h220);
        cdb_en_in = 1'b1; cdb_tag_in = 4'd5; cdb_val_in = 32'h1234;
        #1 chk("hand_cdb_vj", disp_vj_out, 32'h1234);
        chk("hand_cdb_qj", disp_qj_out, 4'd0);
        chk("hand_pend_qk", disp_qk_out, 4'd6);
        chk("hand_pend_vk", disp_vk_out, 32'h0);
        chk("hand_rob_rs_h", rob_rs_h_out, 4'd5);
        step();

        // ROB-ready result outranks a CDB hit on the same tag.
        enq(ADD, 5'd1, 5'd0, 5'd4, 32'h230);
        rob_rs_ready_in = 1'b1; rob_rs_val_in = 32'hAAAA;
        #1 chk("hand_robprio_vj", disp_vj_out, 32'hAAAA);
        chk("hand_x0_vk", disp_vk_out, 32'h0);
        step();
        rob_rs_ready_in = 1'b0; cdb_en_in = 1'b0;

        // Back-to-back rename: ADDI x5 then ADD x6,x5,x5.
        clear_rf();
        rob_full_in = 1'b1; rob_b_in = 4'd2;
        enq(ADDI, 5'd0, 5'd0, 5'd5, 32'h240);
        enq(ADD, 5'd5, 5'd5, 5'd6, 32'h244);
        rob_full_in = 1'b0;
        #1 chk("hand_addi_rden", rf_rd_en_out, 1'b1);
        chk("hand_addi_tag", rf_tag_out, 4'd2);
        chk("hand_addi_rd", rf_rd_out, 5'd5);
        step();
        rob_b_in = 4'd3;
        #1 chk("hand_add_qj", disp_qj_out, 4'd2);
        chk("hand_add_qk", disp_qk_out, 4'd2);
        chk("hand_add_en", disp_en_out, 1'b1);
        step();

        // Stores and branches never rename rd.
        rob_full_in = 1'b1;
        enq(SW, 5'd2, 5'd3, 5'd7, 32'h260);
        enq(BEQ, 5'd2, 5'd3, 5'd7, 32'h264);
        rob_full_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("hand_nrd_en", disp_en_out, 1'b1);
            chk("hand_nrd_rden", rf_rd_en_out, 1'b0);
            step();
        end

        // Flush with two queued and a concurrent enqueue.
        rob_full_in = 1'b1;
        enq(ADD, 5'd1, 5'd1, 5'd8, 32'h280);
        enq(ADD, 5'd1, 5'd1, 5'd9, 32'h284);
        drive(ADD, 5'd1, 5'd1, 5'd9, 32'h300);
        clr_in = 1'b1; rob_full_in = 1'b0;
        #1 chk("hand_flush_en", disp_en_out, 1'b0);
        chk("hand_flush_rden", rf_rd_en_out, 1'b0);
        step();
        clr_in = 1'b0; dec_en_in = 1'b0;
        #1 chk("hand_postflush_en", disp_en_out, 1'b0);
        chk("hand_postflush_full", dq_full_out, 1'b0);
        step();
        #1 chk("hand_postflush2_en", disp_en_out, 1'b0);

        // rdy_in low freezes everything.
        rob_full_in = 1'b1;
        enq(ADDI, 5'd0, 5'd0, 5'd11, 32'h400);
        rob_full_in = 1'b0; rdy_in = 1'b0;
        drive(ADDI, 5'd0, 5'd0, 5'd12, 32'h404);
        #1 chk("hand_rdylow_en", disp_en_out, 1'b0);
        step();
        step();
        rdy_in = 1'b1; dec_en_in = 1'b0;
        #1 chk("hand_rdyhi_pc", disp_pc_out, 32'h400);
        step();

        // Streaming enqueue+dispatch with an RS stall that fills the queue.
        for (int i = 0; i < 8; i++) begin
            drive((i % 3 == 0) ? SW : ADD, 5'(i), 5'(i + 1), 5'(i + 2), 32'h500 + 32'(4 * i));
            rs_full_in = (i >= 3 && i <= 6);
            rob_b_in   = 4'(i + 4);
            step();
        end
        dec_en_in = 1'b0; rs_full_in = 1'b0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
